kt8_mmio: RTL and testbench

- Memory-mapped I/O block for the upper 16 bytes of the KT8 data address space.
- Sits between the CPU data port and the 16-byte data RAM:
  - routes writes to either RAM or I/O registers;
  - muxes read data back to the CPU.
- Provides a GPIO output register, a synchronised GPIO input, an 8-bit prescaled timer with compare/IRQ, and a TX byte FIFO drained over a valid/ready stream.

---
 rtl/kt8_pkg.sv | 42 ++++
 rtl/kt8_byte_fifo.sv | 61 ++++++
 rtl/kt8_mmio.sv | 185 ++++++++++++++++++
 tb/tb_kt8_mmio.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kt8_pkg.sv
// Shared definitions for the KT8 I/O window: register offsets, field bit positions
// and the read-back layout of STATUS.
package kt8_pkg;

    localparam int IO_SEL_BIT = 4;

    localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
    localparam logic [3:0] OFF_TMR_CNT  = 4'h2;
    localparam logic [3:0] OFF_TMR_CMP  = 4'h3;
    localparam logic [3:0] OFF_TMR_CTRL = 4'h4;
    localparam logic [3:0] OFF_TX_DATA  = 4'h5;
    localparam logic [3:0] OFF_STATUS   = 4'h6;
    localparam logic [3:0] OFF_OVF_CLR  = 4'h7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_PS_LSB = 1;
    localparam int CTRL_PS_MSB = 3;
    localparam int CTRL_IE     = 6;
    localparam int CTRL_MATCH  = 7;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_CNT_MSB = 6;
    localparam int ST_MATCH   = 7;

    typedef struct packed {
        logic       match;
        logic [3:0] count;
        logic       ovf;
        logic       empty;
        logic       full;
    } status_t;

    // Terminal prescaler value for a given PS field: 2^PS - 1.
    function automatic logic [7:0] ps_limit(input logic [2:0] ps);
        return 8'((9'd1 << ps) - 9'd1);
    endfunction

endpackage

// File: rtl/kt8_byte_fifo.sv
// Circular byte FIFO; push data is visible at the head one edge after the push, pop is combinational on the head.
// A push into a full FIFO without a same-cycle pop is dropped and flagged on ovf for that cycle.
module kt8_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    head_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push & (~full | pop_ok);
    assign ovf      = push & full & ~pop_ok;
    assign head_dat = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/kt8_mmio.sv
// KT8 upper-16-byte I/O window: RAM/IO decode, GPIO, prescaled compare timer, TX byte FIFO.
// Register writes visible one cycle later; reads are combinational; TX stream pops on valid & ready.
module kt8_mmio
    import kt8_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] addr_i,
    input  logic [7:0] data_i,
    input  logic       we_i,
    output logic [7:0] data_o,
    input  logic [7:0] ram_data_i,
    output logic       ram_we_o,
    input  logic [7:0] gpio_i,
    output logic [7:0] gpio_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          io_sel;
    logic [3:0]    off;
    logic          io_we;
    logic          wr_gpio;
    logic          wr_cnt;
    logic          wr_cmp;
    logic          wr_ctrl;
    logic          wr_tx;
    logic          wr_ovf_clr;

    logic [7:0]    gpio_q;
    logic [7:0]    sync_q [SYNC_STAGES];

    logic [7:0]    tmr_cnt;
    logic [7:0]    tmr_cmp;
    logic [6:0]    tmr_ctrl;
    logic [7:0]    presc;
    logic          tmr_match;
    logic          tmr_en;
    logic [2:0]    tmr_ps;
    logic          tick;
    logic          hit;

    logic          ovf_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic [CW-1:0] fifo_count;
    status_t       status;
    logic [7:0]    rd_dat;

    assign io_sel     = addr_i[IO_SEL_BIT];
    assign off        = addr_i[3:0];
    assign io_we      = we_i & io_sel;
    assign ram_we_o   = we_i & ~io_sel;
    assign wr_gpio    = io_we && (off == OFF_GPIO_OUT);
    assign wr_cnt     = io_we && (off == OFF_TMR_CNT);
    assign wr_cmp     = io_we && (off == OFF_TMR_CMP);
    assign wr_ctrl    = io_we && (off == OFF_TMR_CTRL);
    assign wr_tx      = io_we && (off == OFF_TX_DATA);
    assign wr_ovf_clr = io_we && (off == OFF_OVF_CLR);

    assign gpio_o = gpio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_q <= 8'h00;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
        end else begin
            if (wr_gpio) begin
                gpio_q <= data_i;
            end
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign tmr_en = tmr_ctrl[CTRL_EN];
    assign tmr_ps = tmr_ctrl[CTRL_PS_MSB:CTRL_PS_LSB];
    assign tick   = tmr_en && (presc == ps_limit(tmr_ps));
    assign hit    = tick && (tmr_cnt == tmr_cmp);
    assign irq_o  = tmr_match & tmr_ctrl[CTRL_IE];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_cnt   <= 8'h00;
            tmr_cmp   <= 8'h00;
            tmr_ctrl  <= 7'h00;
            presc     <= 8'h00;
            tmr_match <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                tmr_ctrl <= data_i[6:0];
            end
            if (wr_cmp) begin
                tmr_cmp <= data_i;
            end

            if (wr_ctrl) begin
                presc <= 8'h00;
            end else if (tmr_en) begin
                presc <= tick ? 8'h00 : presc + 8'd1;
            end

            // A CPU load of CNT replaces the whole tick, including its match.
            if (wr_cnt) begin
                tmr_cnt <= data_i;
            end else if (tick) begin
                tmr_cnt <= hit ? 8'h00 : tmr_cnt + 8'd1;
            end

            if (hit && !wr_cnt) begin
                tmr_match <= 1'b1;
            end else if (wr_ctrl && data_i[CTRL_MATCH]) begin
                tmr_match <= 1'b0;
            end
        end
    end

    kt8_byte_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .CW       (CW)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (wr_tx),
        .push_dat (data_i),
        .pop      (tx_ready_i),
        .head_dat (tx_data_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .ovf      (fifo_ovf)
    );

    assign tx_valid_o = ~fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_q <= 1'b1;
        end else if (wr_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign status = '{
        match: tmr_match,
        count: 4'(fifo_count),
        ovf:   ovf_q,
        empty: fifo_empty,
        full:  fifo_full
    };

    always_comb begin
        rd_dat = 8'h00;
        if (!io_sel) begin
            rd_dat = ram_data_i;
        end else begin
            case (off)
                OFF_GPIO_OUT: rd_dat = gpio_q;
                OFF_GPIO_IN:  rd_dat = sync_q[SYNC_STAGES-1];
                OFF_TMR_CNT:  rd_dat = tmr_cnt;
                OFF_TMR_CMP:  rd_dat = tmr_cmp;
                OFF_TMR_CTRL: rd_dat = {tmr_match, tmr_ctrl};
                OFF_STATUS:   rd_dat = status;
                default:      rd_dat = 8'h00;
            endcase
        end
    end

    assign data_o = rd_dat;

endmodule

// File: tb/tb_kt8_mmio.sv
// Directed + randomized bench for kt8_mmio with a queue/arithmetic reference model.
module tb_kt8_mmio;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic [7:0] ram_rdata;
    logic       ram_we;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fq [$];
    logic       fovf = 1'b0;
    logic [7:0] gq [$];
    logic [7:0] d;
    logic [7:0] v;

    always #5 clk = ~clk;

    kt8_mmio #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .addr_i     (addr),
        .data_i     (wdata),
        .we_i       (we),
        .data_o     (rdata),
        .ram_data_i (ram_rdata),
        .ram_we_o   (ram_we),
        .gpio_i     (gpio_in),
        .gpio_o     (gpio_out),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .irq_o      (irq)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] dv);
        addr = a; wdata = dv; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] dv);
        addr = a; we = 1'b0;
        #1;
        dv = rdata;
    endtask

    function automatic logic [7:0] exp_status(input logic m);
        int n;
        n = fq.size();
        return {m, 4'(n), fovf, (n == 0), (n == 4)};
    endfunction

    // One stream cycle: check the head, apply optional push and ready, then check STATUS.
    task automatic fstep(input logic push, input logic [7:0] dv, input logic rdy);
        logic [7:0] s;
        tx_ready = rdy; addr = 5'h15; wdata = dv; we = push;
        #1;
        chk("tx_valid", tx_valid, fq.size() > 0);
        chk("tx_data", tx_data, fq.size() > 0 ? fq[0] : 8'h00);
        if (rdy && fq.size() > 0) void'(fq.pop_front());
        if (push) begin
            if (fq.size() < 4) fq.push_back(dv);
            else fovf = 1'b1;
        end
        cyc();
        we = 1'b0;
        rd(5'h16, s);
        chk("status", s, exp_status(1'b0));
    endtask

    task automatic check_reset_map();
        for (int o = 0; o < 16; o++) begin
            rd(5'(16 + o), d);
            chk("rst_map", d, (o == 6) ? 8'h02 : 8'h00);
        end
    endtask

    initial begin
        int p, cmp, ps, ticks, nc;
        rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0;
        ram_rdata = 8'hC3; gpio_in = 8'h00; tx_ready = 1'b0;

        #2;
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_gpio", gpio_out, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        check_reset_map();

        // RAM routing
        addr = 5'h03; wdata = 8'h5A; we = 1'b1;
        #1;
        chk("ram_we_hi", ram_we, 1'b1);
        chk("ram_rd", rdata, 8'hC3);
        cyc();
        we = 1'b0;
        rd(5'h13, d);
        chk("cmp_untouched", d, 8'h00);
        addr = 5'h13; wdata = 8'h5A; we = 1'b1;
        #1;
        chk("ram_we_lo", ram_we, 1'b0);
        cyc();
        we = 1'b0;
        rd(5'h13, d);
        chk("cmp_wr", d, 8'h5A);

        // GPIO
        wr(5'h10, 8'hA5);
        chk("gpio_o", gpio_out, 8'hA5);
        rd(5'h10, d);
        chk("gpio_out_rd", d, 8'hA5);
        gpio_in = 8'h3C;
        rd(5'h11, d);
        chk("gpio_in_0", d, 8'h00);
        cyc();
        rd(5'h11, d);
        chk("gpio_in_1", d, 8'h00);
        cyc();
        rd(5'h11, d);
        chk("gpio_in_2", d, 8'h3C);
        gq.push_back(8'h3C); gq.push_back(8'h3C);
        for (int i = 0; i < 20; i++) begin
            rd(5'h11, d);
            chk("gpio_in_rand", d, gq[gq.size() - 2]);
            v = 8'($urandom);
            gpio_in = v;
            gq.push_back(v);
            cyc();
        end

        // Timer, PS=0
        wr(5'h13, 8'd3);
        wr(5'h12, 8'd0);
        wr(5'h14, 8'h41);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            rd(5'h12, d);
            chk("tmr_cnt", d, 8'(k % 4));
            chk("tmr_irq", irq, k == 4);
        end
        rd(5'h14, d);
        chk("tmr_ctrl_match", d, 8'hC1);
        wr(5'h14, 8'h80);
        chk("irq_cleared", irq, 1'b0);
        rd(5'h14, d);
        chk("ctrl_w1c", d, 8'h00);

        // Timer, randomized CMP/PS: after k edges, ticks = k / 2^PS
        for (int it = 0; it < 4; it++) begin
            cmp = (it == 0) ? 2 : int'($urandom_range(0, 5));
            ps  = (it == 0) ? 2 : int'($urandom_range(0, 2));
            p   = 1 << ps;
            wr(5'h14, 8'h00);
            wr(5'h14, 8'h80);
            wr(5'h12, 8'h00);
            wr(5'h13, 8'(cmp));
            wr(5'h14, 8'h41 | 8'(ps << 1));
            nc = p * (cmp + 1) * 2 + 3;
            for (int k = 1; k <= nc; k++) begin
                ticks = k / p;
                rd(5'h12, d);
                if (k == 1) chk("tmr_cnt_r0", d, 8'h00);
                cyc();
                rd(5'h12, d);
                chk("tmr_cnt_r", d, 8'(ticks % (cmp + 1)));
                rd(5'h16, d);
                chk("tmr_match_r", d, {(ticks >= cmp + 1), 7'h02});
                chk("tmr_irq_r", irq, ticks >= cmp + 1);
            end
        end
        wr(5'h14, 8'h00);
        wr(5'h14, 8'h80);

        // FIFO fill and overflow
        for (int i = 1; i <= 5; i++) fstep(1'b1, 8'(i), 1'b0);
        rd(5'h16, d);
        chk("fifo_full_ovf", d, 8'h25);
        for (int i = 0; i < 5; i++) fstep(1'b0, 8'h00, 1'b1);
        rd(5'h16, d);
        chk("fifo_empty_ovf", d, 8'h06);
        tx_ready = 1'b0;
        wr(5'h17, 8'h00);
        fovf = 1'b0;
        rd(5'h16, d);
        chk("ovf_clr", d, 8'h02);

        // Full with simultaneous push/pop
        for (int i = 0; i < 4; i++) fstep(1'b1, 8'hA0 + 8'(i), 1'b0);
        fstep(1'b1, 8'h99, 1'b1);
        rd(5'h16, d);
        chk("full_pushpop", d, 8'h21);
        for (int i = 0; i < 5; i++) fstep(1'b0, 8'h00, 1'b1);

        // Random stream traffic
        for (int i = 0; i < 80; i++) begin
            fstep(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0);
            if (i % 16 == 15) begin
                tx_ready = 1'b0;
                wr(5'h17, 8'h00);
                fovf = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) fstep(1'b0, 8'h00, 1'b1);

        // Async reset mid-operation
        gpio_in = 8'h00;
        wr(5'h10, 8'hFF);
        fstep(1'b1, 8'h11, 1'b0);
        fstep(1'b1, 8'h22, 1'b0);
        wr(5'h13, 8'h00);
        wr(5'h12, 8'h00);
        wr(5'h14, 8'h41);
        cyc();
        chk("pre_rst_irq", irq, 1'b1);
        chk("pre_rst_txv", tx_valid, 1'b1);
        chk("pre_rst_gpio", gpio_out, 8'hFF);
        tx_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_txv", tx_valid, 1'b0);
        chk("arst_txd", tx_data, 8'h00);
        chk("arst_irq", irq, 1'b0);
        chk("arst_gpio", gpio_out, 8'h00);
        fq.delete();
        fovf = 1'b0;
        tx_ready = 1'b0;
        #10 rst_n = 1'b1;
        cyc();
        check_reset_map();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
